// File: rtl/serial_host_bridge.sv
// Buffered far end of the processor byte-serial port: a host-to-CPU FIFO, a
// CPU-to-host FIFO, and sticky flags for processor protocol misuse.

module shbFifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] pushData,
  input  logic       pushReq,
  output logic       pushReady,
  input  logic       popReq,
  output logic       popValid,
  output logic [7:0] popData
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1'b1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1'b1);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO   = (DEPTH_LOG2 + 1)'(1'b0);
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            storage_r [DEPTH];
  logic [DEPTH_LOG2-1:0] rdPtr_r;
  logic [DEPTH_LOG2-1:0] wrPtr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic [DEPTH_LOG2:0]   countNext_s;
  logic                  valid_r;
  logic                  ready_r;
  logic                  push_s;
  logic                  pop_s;

  // Handshake qualification and next occupancy.
  always_comb begin
    push_s      = pushReq && ready_r;
    pop_s       = popReq && valid_r;
    countNext_s = count_r;
    case ({push_s, pop_s})
      2'b10:   countNext_s = count_r + CNT_ONE;
      2'b01:   countNext_s = count_r - CNT_ONE;
      default: countNext_s = count_r;
    endcase
  end

  // Pointers, count and status flags; valid/ready are registered from the next count.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdPtr_r <= '0;
      wrPtr_r <= '0;
      count_r <= CNT_ZERO;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        wrPtr_r <= wrPtr_r + PTR_ONE;
      end
      if (pop_s) begin
        rdPtr_r <= rdPtr_r + PTR_ONE;
      end
      count_r <= countNext_s;
      valid_r <= (countNext_s != CNT_ZERO);
      ready_r <= (countNext_s != FULL_COUNT);
    end
  end

  // Byte storage; not reset, and no write lands during reset.
  always_ff @(posedge clock) begin
    if (push_s && !reset) begin
      storage_r[wrPtr_r] <= pushData;
    end
  end

  assign pushReady = ready_r;
  assign popValid  = valid_r;
  assign popData   = storage_r[rdPtr_r];

endmodule

module serial_host_bridge #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] cpu_rdata,
  output logic       cpu_rvalid,
  input  logic       cpu_ren,
  output logic       cpu_wready,
  input  logic [7:0] cpu_wdata,
  input  logic       cpu_wen,
  input  logic [7:0] host_in_data,
  input  logic       host_in_valid,
  output logic       host_in_ready,
  output logic [7:0] host_out_data,
  output logic       host_out_valid,
  input  logic       host_out_ready,
  output logic       overflow,
  output logic       underflow,
  input  logic       clear_flags
);

  logic overflow_r;
  logic underflow_r;
  logic overflowSet_s;
  logic underflowSet_s;

  shbFifo #(.DEPTH_LOG2(DEPTH_LOG2)) toCpuFifo (
    .clock     (clock),
    .reset     (reset),
    .pushData  (host_in_data),
    .pushReq   (host_in_valid),
    .pushReady (host_in_ready),
    .popReq    (cpu_ren),
    .popValid  (cpu_rvalid),
    .popData   (cpu_rdata)
  );

  shbFifo #(.DEPTH_LOG2(DEPTH_LOG2)) fromCpuFifo (
    .clock     (clock),
    .reset     (reset),
    .pushData  (cpu_wdata),
    .pushReq   (cpu_wen),
    .pushReady (cpu_wready),
    .popReq    (host_out_ready),
    .popValid  (host_out_valid),
    .popData   (host_out_data)
  );

  // Misuse detection: requests issued against a blocked FIFO side.
  always_comb begin
    overflowSet_s  = cpu_wen && !cpu_wready;
    underflowSet_s = cpu_ren && !cpu_rvalid;
  end

  // Sticky flags; a fresh error outranks a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (overflowSet_s) begin
        overflow_r <= 1'b1;
      end else if (clear_flags) begin
        overflow_r <= 1'b0;
      end
      if (underflowSet_s) begin
        underflow_r <= 1'b1;
      end else if (clear_flags) begin
        underflow_r <= 1'b0;
      end
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: doc/serial_host_bridge.md
# serial_host_bridge

Buffered far end of the processor's byte-serial IO port. It sits between the data-memory serial pins and an external host byte stream. It holds one FIFO of bytes to be read by the processor and one FIFO of bytes written by the processor. Each FIFO side uses a valid/ready handshake, and sticky error flags catch protocol misuse by the processor.

## Interface
Parameters:
- DEPTH_LOG2, 3, log2 of each FIFO depth (depth = 8 entries by default); legal range 1..8.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- cpu_rdata  output  8  head byte of the to-CPU FIFO; wires to processor serial_in
- cpu_rvalid  output  1  to-CPU FIFO not empty; wires to processor serial_valid_in
- cpu_ren  input  1  one-cycle pop request from processor (serial_rden_out)
- cpu_wready  output  1  from-CPU FIFO not full; wires to processor serial_ready_in
- cpu_wdata  input  8  byte from processor (serial_out)
- cpu_wen  input  1  one-cycle push request from processor (serial_wren_out)
- host_in_data  input  8  byte offered by host
- host_in_valid  input  1  host offers host_in_data
- host_in_ready  output  1  bridge accepts host byte this cycle
- host_out_data  output  8  head byte of the from-CPU FIFO
- host_out_valid  output  1  from-CPU FIFO not empty
- host_out_ready  input  1  host consumes host_out_data this cycle
- overflow  output  1  sticky: cpu_wen seen while from-CPU FIFO full
- underflow  output  1  sticky: cpu_ren seen while to-CPU FIFO empty
- clear_flags  input  1  synchronous clear of overflow/underflow

## Operation
- There are two independent circular FIFOs, each with depth 2^DEPTH_LOG2 and 8 bits per entry.
- Each FIFO has a read pointer, a write pointer and an occupancy count of DEPTH_LOG2+1 bits.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth.
- To-CPU FIFO (host to processor):
  - Push occurs when host_in_valid && host_in_ready.
  - Pop occurs when cpu_ren && cpu_rvalid.
- From-CPU FIFO (processor to host):
  - Push occurs when cpu_wen && cpu_wready.
  - Pop occurs when host_out_valid && host_out_ready.
- All status outputs are derived from registered counts:
  - valid = (count != 0)
  - ready = (count != depth)
- Data outputs present the entry at the read pointer and are combinational from storage.
- Simultaneous push and pop on a non-empty, non-full FIFO: both happen and the count is unchanged.
- Full FIFO: ready is low in that cycle even if a pop also occurs, so the push is not taken; ready rises the cycle after the pop.
- Empty FIFO: valid is low, so no pop is possible in the same cycle as the first push.
- cpu_wen while cpu_wready = 0: the byte is dropped, overflow is set, and FIFO state is unchanged.
- cpu_ren while cpu_rvalid = 0: nothing is popped and underflow is set.
- cpu_ren or cpu_wen held high for N cycles counts as N requests. The processor must pulse them.
- Error flags and clear_flags:
  - clear_flags clears both flags.
  - A new error event in the same cycle as clear_flags wins: the flag ends up set.
- Host side follows standard valid/ready rules:
  - host_in_data must be stable while host_in_valid is high and host_in_ready is low.
  - The bridge holds host_out_data stable until the pop.

## Timing
- Reset values:
  - all pointers and counts = 0
  - cpu_rvalid = 0, host_out_valid = 0
  - cpu_wready = 1, host_in_ready = 1
  - overflow = 0, underflow = 0
- Data outputs during reset: cpu_rdata and host_out_data = storage[0]. The storage array itself is not reset.
- Latency:
  - A byte pushed at edge k is visible on the opposite valid/data outputs after edge k (next cycle).
  - Minimum host-to-processor latency is 1 cycle.
- Throughput: one push and one pop per FIFO per cycle.
- Reset mid-operation: in-flight bytes are discarded, flags are cleared, and no handshake completes in the reset cycle.
- cpu_ren is sampled at the edge, and cpu_rdata advances to the next entry after that edge. The processor's data memory must latch cpu_rdata in the cycle it asserts cpu_ren.

## Test plan
- Reset, then idle:
  - cpu_rvalid = 0, host_out_valid = 0
  - cpu_wready = 1, host_in_ready = 1
  - overflow = 0, underflow = 0
- Host pushes 0x48, 0x69 on consecutive cycles:
  - cpu_rvalid rises one cycle after the first push, with cpu_rdata = 0x48.
  - After one cpu_ren pulse, cpu_rdata = 0x69.
  - After a second pulse, cpu_rvalid = 0.
- Processor writes 9 bytes 0x00..0x08 (depth 8) with host_out_ready = 0:
  - cpu_wready drops after the 8th write.
  - The 9th write sets overflow.
  - Host then drains 0x00..0x07 in order, and host_out_valid = 0 afterwards.
- Wrap-around: stream 20 bytes through the to-CPU FIFO with random host valid and CPU ren gaps. The received sequence must equal the sent sequence, with no flags set.
- Full FIFO with simultaneous host_out_ready and cpu_wen:
  - The pop occurs and the push is refused (overflow set).
  - Next cycle cpu_wready = 1.
- Error flags and reset:
  - cpu_ren on empty sets underflow.
  - clear_flags together with another empty cpu_ren leaves underflow = 1.
  - Reset asserted with 3 bytes queued empties both FIFOs and clears the flags on the next edge.
